// File: rtl/apb_arb_pkg.sv
// Shared types and helpers for the APB requester-side arbiter.
//   state_e   : bus sequencing states (idle, setup, access)
//   idx_width : width of a requester index for a given requester count
package apb_arb_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSetup  = 2'd1,
    StAccess = 2'd2
  } state_e;

  // A single requester still needs one index bit so vectors never collapse to zero width.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
// Ports:
//   req       : request vector, one bit per requester
//   ptr       : highest-priority requester index this cycle
//   grant     : one-hot grant (all zero when nothing requests)
//   grant_idx : binary index of the granted requester
//   any       : at least one request present
module rr_arbiter #(
  parameter int unsigned NumReq   = 2,
  parameter int unsigned IdxWidth = 1
) (
  input  logic [NumReq-1:0]   req,
  input  logic [IdxWidth-1:0] ptr,
  output logic [NumReq-1:0]   grant,
  output logic [IdxWidth-1:0] grant_idx,
  output logic                any
);

  int unsigned         slot;
  logic [IdxWidth-1:0] slot_idx;

  // Walk from ptr upwards with wrap-around; the first set bit wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    slot      = 0;
    slot_idx  = '0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      slot = 32'(ptr) + k;
      if (slot >= NumReq) begin
        slot = slot - NumReq;
      end
      slot_idx = IdxWidth'(slot);
      if (!any && req[slot_idx]) begin
        any             = 1'b1;
        grant[slot_idx] = 1'b1;
        grant_idx       = slot_idx;
      end
    end
  end

endmodule

// File: rtl/apb_master_arbiter.sv
// APB3 requester-side controller sharing one APB bus among NUM_REQ local requesters with
// round-robin arbitration.
// Optional feature: define APB_TIMEOUT_EN to abort an ACCESS phase that has waited
// TIMEOUT_CYCLES cycles with pready low (completes with rsp_err=1, rsp_rdata=0).
// Ports:
//   pclk, preset            : clock, asynchronous active-high reset
//   req_valid/ready         : per-requester handshake; req_ready is a combinational IDLE-only pulse
//   req_addr/write/wdata    : packed per-requester transfer attributes
//   rsp_valid/rdata/err     : one-cycle registered completion, one-hot in rsp_valid
//   psel..pwdata            : registered APB request signals
//   prdata, pready, pslverr : APB completion inputs, only observed in ACCESS
module apb_master_arbiter
  import apb_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                           pclk,
  input  logic                           preset,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_REQ-1:0]             req_write,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [DATA_WIDTH-1:0]          rsp_rdata,
  output logic                           rsp_err,
  output logic                           psel,
  output logic                           penable,
  output logic                           pwrite,
  output logic [ADDR_WIDTH-1:0]          paddr,
  output logic [DATA_WIDTH-1:0]          pwdata,
  input  logic [DATA_WIDTH-1:0]          prdata,
  input  logic                           pready,
  input  logic                           pslverr
);

  localparam int unsigned IdxW = idx_width(NUM_REQ);

  state_e              state_q;
  logic [IdxW-1:0]     ptr_q;
  logic [IdxW-1:0]     cur_q;
  logic [NUM_REQ-1:0]  grant;
  logic [IdxW-1:0]     grant_idx;
  logic                any_req;
  logic                timeout;

  rr_arbiter #(
    .NumReq   (NUM_REQ),
    .IdxWidth (IdxW)
  ) u_rr_arbiter (
    .req       (req_valid),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (any_req)
  );

  assign req_ready = (state_q == StIdle) ? grant : '0;

`ifdef APB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CntW-1:0] cnt_q;

  // cnt_q counts completed wait cycles, so the limit is hit during the last allowed cycle.
  always_comb begin
    timeout = (state_q == StAccess) && !pready && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;

  always_comb begin
    timeout = 1'b0;
  end
`endif

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q   <= StIdle;
      ptr_q     <= '0;
      cur_q     <= '0;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
`ifdef APB_TIMEOUT_EN
      cnt_q     <= '0;
`endif
    end else begin
      // Responses are single-cycle pulses.
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (any_req) begin
            psel    <= 1'b1;
            paddr   <= req_addr[32'(grant_idx) * ADDR_WIDTH +: ADDR_WIDTH];
            pwrite  <= req_write[grant_idx];
            pwdata  <= req_wdata[32'(grant_idx) * DATA_WIDTH +: DATA_WIDTH];
            cur_q   <= grant_idx;
            ptr_q   <= (grant_idx == IdxW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
            state_q <= StSetup;
          end
        end
        StSetup: begin
          penable <= 1'b1;
`ifdef APB_TIMEOUT_EN
          cnt_q   <= '0;
`endif
          state_q <= StAccess;
        end
        StAccess: begin
          if (pready || timeout) begin
            psel      <= 1'b0;
            penable   <= 1'b0;
            rsp_valid <= NUM_REQ'(1) << cur_q;
            // pready wins over a coincident timeout.
            rsp_err   <= pready ? pslverr : 1'b1;
            rsp_rdata <= (pready && !pwrite) ? prdata : '0;
            state_q   <= StIdle;
          end
`ifdef APB_TIMEOUT_EN
          else begin
            cnt_q <= cnt_q + 1'b1;
          end
`endif
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_arbiter.sv
module tb_apb_master_arbiter;

  localparam int NR = 3;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int TO = 16;

  logic              pclk;
  logic              preset;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR*AW-1:0]  req_addr;
  logic [NR-1:0]     req_write;
  logic [NR*DW-1:0]  req_wdata;
  logic [NR-1:0]     rsp_valid;
  logic [DW-1:0]     rsp_rdata;
  logic              rsp_err;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [AW-1:0]     paddr;
  logic [DW-1:0]     pwdata;
  logic [DW-1:0]     prdata;
  logic              pready;
  logic              pslverr;

  int n_assert = 0;
  int n_fail   = 0;
  int ptr_m    = 0;  // reference round-robin pointer

  apb_master_arbiter #(
    .NUM_REQ        (NR),
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .pclk      (pclk),
    .preset    (preset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_write (req_write),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .psel      (psel),
    .penable   (penable),
    .pwrite    (pwrite),
    .paddr     (paddr),
    .pwdata    (pwdata),
    .prdata    (prdata),
    .pready    (pready),
    .pslverr   (pslverr)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NR-1:0] onehot(input int g);
    logic [NR-1:0] v;
    v    = '0;
    v[g] = 1'b1;
    return v;
  endfunction

  // Reference pick: first requesting index at or after the pointer, wrapping.
  function automatic int model_pick(input logic [NR-1:0] vset);
    for (int k = 0; k < NR; k++) begin
      if (vset[(ptr_m + k) % NR]) return (ptr_m + k) % NR;
    end
    return -1;
  endfunction

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic w,
                         input logic [DW-1:0] d);
    req_addr[i*AW +: AW]  = a;
    req_write[i]          = w;
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic randomize_reqs();
    for (int i = 0; i < NR; i++) set_req(i, AW'($urandom), 1'($urandom), $urandom);
  endtask

  // Accept phase: called at a negedge with the DUT idle; returns at the SETUP-cycle negedge.
  task automatic start_xfer(input logic [NR-1:0] vset, output int g, output logic [AW-1:0] ea,
                            output logic ew, output logic [DW-1:0] ed);
    g  = model_pick(vset);
    ea = req_addr[g*AW +: AW];
    ew = req_write[g];
    ed = req_wdata[g*DW +: DW];
    req_valid = vset;
    #1;
    check("req_ready_accept", {61'd0, req_ready}, {61'd0, onehot(g)});
    ptr_m = (g + 1) % NR;
    @(negedge pclk);
    req_valid = '0;
    randomize_reqs();
    #1;
    check("setup_psel", {63'd0, psel}, 64'd1);
    check("setup_penable", {63'd0, penable}, 64'd0);
    check("setup_paddr", {56'd0, paddr}, {56'd0, ea});
    check("setup_pwrite", {63'd0, pwrite}, {63'd0, ew});
    check("setup_pwdata", {32'd0, pwdata}, {32'd0, ed});
    check("setup_rsp_clear", {61'd0, rsp_valid}, 64'd0);
    check("setup_rdata_clear", {32'd0, rsp_rdata}, 64'd0);
    @(negedge pclk);
  endtask

  task automatic xfer(input logic [NR-1:0] vset, input int waits, input logic err_in,
                      input logic [DW-1:0] rdv);
    int            g;
    logic [AW-1:0] ea;
    logic          ew;
    logic [DW-1:0] ed;
    start_xfer(vset, g, ea, ew, ed);
    for (int c = 0; c <= waits; c++) begin
      // Noise on ignored inputs: new requests and wait-state pslverr/prdata.
      req_valid = NR'($urandom);
      pready    = (c == waits);
      pslverr   = (c == waits) ? err_in : 1'($urandom);
      prdata    = (c == waits) ? rdv : $urandom;
      #1;
      check("access_psel_penable", {62'd0, psel, penable}, 64'd3);
      check("access_paddr", {56'd0, paddr}, {56'd0, ea});
      check("access_req_ready", {61'd0, req_ready}, 64'd0);
      @(negedge pclk);
    end
    req_valid = '0;
    pready    = 1'b0;
    pslverr   = 1'b0;
    #1;
    check("rsp_valid", {61'd0, rsp_valid}, {61'd0, onehot(g)});
    check("rsp_err", {63'd0, rsp_err}, {63'd0, err_in});
    check("rsp_rdata", {32'd0, rsp_rdata}, ew ? 64'd0 : {32'd0, rdv});
    check("end_psel", {62'd0, psel, penable}, 64'd0);
  endtask

  initial begin
    int            g;
    int            n;
    logic [AW-1:0] ea;
    logic          ew;
    logic [DW-1:0] ed;

    preset    = 1'b0;
    req_valid = '0;
    req_addr  = '0;
    req_write = '0;
    req_wdata = '0;
    prdata    = '0;
    pready    = 1'b0;
    pslverr   = 1'b0;
    #1 preset = 1'b1;
    #2;
    check("reset_psel", {62'd0, psel, penable}, 64'd0);
    check("reset_pwrite", {63'd0, pwrite}, 64'd0);
    check("reset_paddr", {56'd0, paddr}, 64'd0);
    check("reset_pwdata", {32'd0, pwdata}, 64'd0);
    check("reset_rsp", {28'd0, rsp_valid, rsp_err, rsp_rdata}, 64'd0);
    check("reset_req_ready", {61'd0, req_ready}, 64'd0);
    @(negedge pclk);
    @(negedge pclk);
    preset = 1'b0;
    ptr_m  = 0;

    // 1: write from req0, zero wait states
    set_req(0, 8'h10, 1'b1, 32'hDEADBEEF);
    xfer(3'b001, 0, 1'b0, 32'h0);
    // 2: read from req1 with three wait states
    set_req(1, 8'h20, 1'b0, 32'h0);
    xfer(3'b010, 3, 1'b0, 32'h12345678);
    // 3: req0 and req1 contending, back to back
    for (int i = 0; i < 4; i++) begin
      randomize_reqs();
      xfer(3'b011, i % 2, 1'b0, $urandom);
    end
    // 4: read error with data
    set_req(2, 8'h44, 1'b0, 32'h0);
    xfer(3'b100, 0, 1'b1, 32'hCAFEF00D);
    // Randomised contention across all requesters
    for (int i = 0; i < 25; i++) begin
      randomize_reqs();
      xfer(NR'($urandom_range(1, 7)), $urandom_range(0, 4), 1'($urandom), $urandom);
    end

    // 5: reset pulse while req0 is in ACCESS
    while (ptr_m != 0) begin
      randomize_reqs();
      xfer(3'b111, 0, 1'b0, $urandom);
    end
    set_req(0, 8'h55, 1'b0, 32'h0);
    start_xfer(3'b001, g, ea, ew, ed);  // pointer now 1
    #2 preset = 1'b1;
    #1;
    check("async_reset_bus", {62'd0, psel, penable}, 64'd0);
    #1 preset = 1'b0;
    ptr_m = 0;
    @(negedge pclk);
    check("post_reset_no_rsp", {61'd0, rsp_valid}, 64'd0);
    check("post_reset_idle", {63'd0, psel}, 64'd0);
    randomize_reqs();
    xfer(3'b011, 1, 1'b0, $urandom);  // model expects req0

    // 6: pready never asserted
    set_req(1, 8'h66, 1'b0, 32'h0);
    start_xfer(3'b010, g, ea, ew, ed);
    n = 0;
`ifdef APB_TIMEOUT_EN
    while (rsp_valid == '0 && n < 40) begin
      @(negedge pclk);
      n++;
    end
    check("timeout_cycles", 64'(n), 64'(TO));
    check("timeout_rsp_valid", {61'd0, rsp_valid}, {61'd0, onehot(g)});
    check("timeout_err", {63'd0, rsp_err}, 64'd1);
    check("timeout_rdata", {32'd0, rsp_rdata}, 64'd0);
`else
    repeat (100) begin
      prdata = $urandom;
      @(negedge pclk);
      if (rsp_valid != '0) n++;
    end
    check("hang_no_rsp", 64'(n), 64'd0);
    check("hang_still_access", {62'd0, psel, penable}, 64'd3);
    preset = 1'b1;
    #1 preset = 1'b0;
    ptr_m = 0;
`endif
    @(negedge pclk);
    randomize_reqs();
    xfer(3'b110, 2, 1'b0, $urandom);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
